// File: rtl/darkbridge.sv
// darkbridge: UART debug bridge acting as a second bus master.
// 'W' + addr + data writes a word, 'R' + addr reads one; replies are sent back on TXD.
module darkbridge #(
   parameter logic [15:0] BAUD = 16'd868,
   parameter logic [7:0]  TOUT = 8'd20
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        RXD,
   output logic        TXD,
   output logic [31:0] ADDR,
   output logic        RD,
   output logic        WR,
   output logic [3:0]  BE,
   output logic [31:0] DATAO,
   input  logic [31:0] DATAI,
   input  logic        HLT,
   output logic        BUSY
);
   // state  | meaning
   // S_IDLE | waiting for a command byte
   // S_ADDR | collecting address bytes A0..A3
   // S_DATA | collecting write data bytes D0..D3
   // S_BUS  | bus request outstanding
   // S_RESP | sending the response byte(s)
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

   localparam logic [15:0] BAUD_M1 = BAUD - 16'd1;
   localparam logic [15:0] HALF_M1 = (BAUD >> 1) - 16'd1;
   localparam logic [23:0] TMO_M1  = 24'(TOUT) * 24'(BAUD) - 24'd1;

   state_t      state, state_nx;
   logic        rxd_m, rxd_s, rxd_d;
   logic        rx_act, rx_valid;
   logic [15:0] rx_baud;
   logic [3:0]  rx_bit;
   logic [7:0]  rx_shift, rx_byte;
   logic        tx_act, tx_start, tx_done;
   logic [15:0] tx_baud;
   logic [3:0]  tx_bit;
   logic [7:0]  tx_shift, tx_data;
   logic        cmd_wr, cmd_bad, tmo_hit;
   logic [1:0]  byte_cnt, resp_cnt, resp_last;
   logic [23:0] tmo_cnt;
   logic [31:0] rdata;

   // receiver: rx_bit 0 = start recheck, 1..8 = data, 9 = stop
   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         rxd_m    <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_d    <= 1'b1;
         rx_act   <= 1'b0;
         rx_baud  <= 16'd0;
         rx_bit   <= 4'd0;
         rx_shift <= 8'd0;
         rx_byte  <= 8'd0;
         rx_valid <= 1'b0;
      end else begin
         rxd_m    <= RXD;
         rxd_s    <= rxd_m;
         rxd_d    <= rxd_s;
         rx_valid <= 1'b0;
         if (!rx_act) begin
            if (rxd_d && !rxd_s) begin
               rx_act  <= 1'b1;
               rx_baud <= HALF_M1;
               rx_bit  <= 4'd0;
            end
         end else if (rx_baud != 16'd0) begin
            rx_baud <= rx_baud - 16'd1;
         end else begin
            rx_baud <= BAUD_M1;
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
               if (rxd_s) rx_act <= 1'b0;
            end else if (rx_bit == 4'd9) begin
               rx_act <= 1'b0;
               if (rxd_s) begin
                  rx_byte  <= rx_shift;
                  rx_valid <= 1'b1;
               end
            end else begin
               rx_shift <= {rxd_s, rx_shift[7:1]};
            end
         end
      end
   end

   // transmitter: shifting in ones makes the stop bit fall out after data bit 7
   assign tx_done = tx_act && (tx_baud == 16'd0) && (tx_bit == 4'd9);

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         TXD      <= 1'b1;
         tx_act   <= 1'b0;
         tx_baud  <= 16'd0;
         tx_bit   <= 4'd0;
         tx_shift <= 8'hFF;
      end else if (tx_start) begin
         TXD      <= 1'b0;
         tx_act   <= 1'b1;
         tx_baud  <= BAUD_M1;
         tx_bit   <= 4'd0;
         tx_shift <= tx_data;
      end else if (tx_act) begin
         if (tx_baud != 16'd0) begin
            tx_baud <= tx_baud - 16'd1;
         end else if (tx_bit == 4'd9) begin
            tx_act <= 1'b0;
         end else begin
            TXD      <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[7:1]};
            tx_bit   <= tx_bit + 4'd1;
            tx_baud  <= BAUD_M1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      tmo_hit   = (state == S_ADDR || state == S_DATA) && (tmo_cnt == 24'd0);
      tx_start  = (state == S_RESP) && !tx_act;
      resp_last = (cmd_bad || cmd_wr) ? 2'd0 : 2'd3;
      tx_data   = 8'h3F;
      if (!cmd_bad) begin
         if (cmd_wr) tx_data = 8'h2E;
         else begin
            case (resp_cnt)
               2'd0:    tx_data = rdata[7:0];
               2'd1:    tx_data = rdata[15:8];
               2'd2:    tx_data = rdata[23:16];
               default: tx_data = rdata[31:24];
            endcase
         end
      end
      case (state)
         S_IDLE: if (rx_valid)
                    state_nx = (rx_byte == 8'h57 || rx_byte == 8'h52) ? S_ADDR : S_RESP;
         S_ADDR: if (tmo_hit) state_nx = S_IDLE;
                 else if (rx_valid && byte_cnt == 2'd3) state_nx = cmd_wr ? S_DATA : S_BUS;
         S_DATA: if (tmo_hit) state_nx = S_IDLE;
                 else if (rx_valid && byte_cnt == 2'd3) state_nx = S_BUS;
         S_BUS:  if ((RD || WR) && !HLT) state_nx = S_RESP;
         S_RESP: if (tx_done && resp_cnt == resp_last) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   assign BUSY = (state != S_IDLE);

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         cmd_wr   <= 1'b0;
         cmd_bad  <= 1'b0;
         byte_cnt <= 2'd0;
         resp_cnt <= 2'd0;
         tmo_cnt  <= 24'd0;
         ADDR     <= 32'd0;
         DATAO    <= 32'd0;
         rdata    <= 32'd0;
         RD       <= 1'b0;
         WR       <= 1'b0;
         BE       <= 4'h0;
      end else begin
         if (rx_valid) tmo_cnt <= TMO_M1;
         else if (tmo_cnt != 24'd0 && (state == S_ADDR || state == S_DATA))
            tmo_cnt <= tmo_cnt - 24'd1;
         case (state)
            S_IDLE: if (rx_valid) begin
                       cmd_wr   <= (rx_byte == 8'h57);
                       cmd_bad  <= !(rx_byte == 8'h57 || rx_byte == 8'h52);
                       byte_cnt <= 2'd0;
                       resp_cnt <= 2'd0;
                    end
            S_ADDR: if (rx_valid) begin
                       ADDR     <= {rx_byte, ADDR[31:8]};
                       byte_cnt <= byte_cnt + 2'd1;
                    end
            S_DATA: if (rx_valid) begin
                       DATAO    <= {rx_byte, DATAO[31:8]};
                       byte_cnt <= byte_cnt + 2'd1;
                    end
            S_BUS:  if (!RD && !WR) begin
                       RD <= !cmd_wr;
                       WR <= cmd_wr;
                       BE <= 4'hF;
                    end else if (!HLT) begin
                       RD <= 1'b0;
                       WR <= 1'b0;
                       BE <= 4'h0;
                       if (RD) rdata <= DATAI;
                    end
            S_RESP: if (tx_done) resp_cnt <= resp_cnt + 2'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_darkbridge.sv
// Directed bench for darkbridge: drives serial frames, watches the bus and decodes TXD.
module tb_darkbridge;
   localparam int BAUD = 16;

   logic        CLK = 1'b0;
   logic        RES, RXD, TXD, RD, WR, HLT, BUSY;
   logic [31:0] ADDR, DATAO, DATAI;
   logic [3:0]  BE;

   darkbridge #(.BAUD(16'd16), .TOUT(8'd24)) dut (
      .CLK(CLK), .RES(RES), .RXD(RXD), .TXD(TXD), .ADDR(ADDR), .RD(RD), .WR(WR),
      .BE(BE), .DATAO(DATAO), .DATAI(DATAI), .HLT(HLT), .BUSY(BUSY));

   always #5 CLK = ~CLK;

   int n_asserts = 0;
   int n_fail = 0;

   // bus watcher: transactions counted on request rising edges
   int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
   logic        rd_prev = 1'b0, wr_prev = 1'b0;
   logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
   logic [3:0]  rd_be = '0, wr_be = '0;

   always @(negedge CLK) begin
      if (RD && WR) both_cnt <= both_cnt + 1;
      if (RD && !rd_prev) begin
         rd_cnt  <= rd_cnt + 1;
         rd_addr <= ADDR;
         rd_be   <= BE;
      end
      if (WR && !wr_prev) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= ADDR;
         wr_data <= DATAO;
         wr_be   <= BE;
      end
      rd_prev <= RD;
      wr_prev <= WR;
   end

   // serial decoder for TXD, sampling mid-bit
   logic [7:0] tx_log [0:63];
   int         tx_count = 0;
   int         tx_bad_stop = 0;
   logic [7:0] mon_b;

   initial forever begin
      @(negedge CLK);
      if (RES === 1'b0 && TXD === 1'b0) begin
         repeat (BAUD/2 - 1) @(negedge CLK);
         for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge CLK);
            mon_b[i] = TXD;
         end
         repeat (BAUD) @(negedge CLK);
         if (TXD !== 1'b1) tx_bad_stop = tx_bad_stop + 1;
         if (tx_count < 64) tx_log[tx_count] = mon_b;
         tx_count = tx_count + 1;
      end
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stopv, input int tail);
      RXD = 1'b0;
      repeat (BAUD) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         repeat (BAUD) @(negedge CLK);
      end
      RXD = stopv;
      if (tail > 0) begin
         repeat (BAUD) @(negedge CLK);
         RXD = 1'b1;
         repeat (tail) @(negedge CLK);
      end
   endtask

   task automatic wait_tx(input string tag, input int n);
      for (int i = 0; i < 4000 && tx_count < n; i++) @(negedge CLK);
      check32(tag, tx_count, n);
   endtask

   task automatic wait_req(input string tag, input logic want_rd);
      for (int i = 0; i < 60 && (want_rd ? RD : WR) !== 1'b1; i++) @(negedge CLK);
      check32(tag, want_rd ? RD : WR, 1);
   endtask

   int base, r0, w0, held;

   initial begin
      RES = 1'b1; RXD = 1'b1; HLT = 1'b0; DATAI = 32'd0;
      repeat (3) @(negedge CLK);
      check32("rst_txd",   TXD,   1);
      check32("rst_rd",    RD,    0);
      check32("rst_wr",    WR,    0);
      check32("rst_be",    BE,    0);
      check32("rst_addr",  ADDR,  0);
      check32("rst_datao", DATAO, 0);
      check32("rst_busy",  BUSY,  0);
      RES = 1'b0;
      repeat (4) @(negedge CLK);

      // write 0xDEADBEEF to 0x00001000
      base = tx_count; r0 = rd_cnt; w0 = wr_cnt;
      send_byte(8'h57, 1'b1, 2);
      check32("busy_after_cmd", BUSY, 1);
      send_byte(8'h00, 1'b1, 2); send_byte(8'h10, 1'b1, 2);
      send_byte(8'h00, 1'b1, 2); send_byte(8'h00, 1'b1, 2);
      send_byte(8'hEF, 1'b1, 2); send_byte(8'hBE, 1'b1, 2);
      send_byte(8'hAD, 1'b1, 2); send_byte(8'hDE, 1'b1, 2);
      wait_tx("wr_tx_count", base + 1);
      check32("wr_resp",   tx_log[base], 8'h2E);
      check32("wr_pulses", wr_cnt - w0, 1);
      check32("wr_no_rd",  rd_cnt - r0, 0);
      check32("wr_addr",   wr_addr, 32'h0000_1000);
      check32("wr_data",   wr_data, 32'hDEAD_BEEF);
      check32("wr_be",     wr_be, 4'hF);
      repeat (BAUD) @(negedge CLK);
      check32("wr_busy_end", BUSY, 0);

      // read 0x80000004 -> 0x12345678
      base = tx_count; r0 = rd_cnt; w0 = wr_cnt;
      DATAI = 32'h1234_5678;
      send_byte(8'h52, 1'b1, 2); send_byte(8'h04, 1'b1, 2); send_byte(8'h00, 1'b1, 2);
      send_byte(8'h00, 1'b1, 2); send_byte(8'h80, 1'b1, 2);
      wait_tx("rd_tx_count", base + 4);
      check32("rd_b0", tx_log[base],     8'h78);
      check32("rd_b1", tx_log[base + 1], 8'h56);
      check32("rd_b2", tx_log[base + 2], 8'h34);
      check32("rd_b3", tx_log[base + 3], 8'h12);
      check32("rd_pulses", rd_cnt - r0, 1);
      check32("rd_no_wr",  wr_cnt - w0, 0);
      check32("rd_addr",   rd_addr, 32'h8000_0004);
      check32("rd_be",     rd_be, 4'hF);
      repeat (BAUD) @(negedge CLK);
      check32("rd_busy_end", BUSY, 0);

      // unknown command
      base = tx_count; r0 = rd_cnt; w0 = wr_cnt;
      send_byte(8'h41, 1'b1, 2);
      wait_tx("bad_tx_count", base + 1);
      check32("bad_resp",  tx_log[base], 8'h3F);
      check32("bad_no_rd", rd_cnt - r0, 0);
      check32("bad_no_wr", wr_cnt - w0, 0);
      repeat (BAUD) @(negedge CLK);
      check32("bad_busy_end", BUSY, 0);

      // read held off by HLT for 7 cycles
      base = tx_count; r0 = rd_cnt;
      HLT = 1'b1; DATAI = 32'hBAD0_BAD0;
      send_byte(8'h52, 1'b1, 2); send_byte(8'h20, 1'b1, 2); send_byte(8'h00, 1'b1, 2);
      send_byte(8'h00, 1'b1, 2); send_byte(8'h00, 1'b1, 0);
      wait_req("hlt_rd_rise", 1'b1);
      held = 1;
      repeat (7) begin
         @(negedge CLK);
         if (RD === 1'b1 && ADDR === 32'h0000_0020 && BE === 4'hF) held++;
      end
      HLT = 1'b0; DATAI = 32'hCAFE_F00D;
      @(negedge CLK);
      DATAI = 32'hBAD0_BAD0;
      check32("hlt_rd_drop",  RD, 0);
      check32("hlt_rd_held",  held, 8);
      check32("hlt_be_drop",  BE, 0);
      wait_tx("hlt_tx_count", base + 4);
      check32("hlt_b0", tx_log[base],     8'h0D);
      check32("hlt_b1", tx_log[base + 1], 8'hF0);
      check32("hlt_b2", tx_log[base + 2], 8'hFE);
      check32("hlt_b3", tx_log[base + 3], 8'hCA);
      check32("hlt_pulses", rd_cnt - r0, 1);
      repeat (BAUD) @(negedge CLK);

      // framing error on 2nd address byte, then resent
      base = tx_count; r0 = rd_cnt; w0 = wr_cnt;
      DATAI = 32'h0BAD_CAFE;
      send_byte(8'h52, 1'b1, 2); send_byte(8'h10, 1'b1, 2);
      send_byte(8'h20, 1'b0, 2);
      send_byte(8'h20, 1'b1, 2); send_byte(8'h30, 1'b1, 2); send_byte(8'h40, 1'b1, 2);
      wait_tx("fe_tx_count", base + 4);
      check32("fe_addr",   rd_addr, 32'h4030_2010);
      check32("fe_pulses", rd_cnt - r0, 1);
      check32("fe_no_wr",  wr_cnt - w0, 0);
      check32("fe_b0", tx_log[base],     8'hFE);
      check32("fe_b3", tx_log[base + 3], 8'h0B);
      repeat (BAUD) @(negedge CLK);

      // partial frame then silence beyond the timeout
      base = tx_count; r0 = rd_cnt;
      send_byte(8'h52, 1'b1, 2); send_byte(8'h01, 1'b1, 2); send_byte(8'h02, 1'b1, 2);
      repeat (500) @(negedge CLK);
      check32("tmo_busy",  BUSY, 0);
      check32("tmo_no_tx", tx_count, base);
      check32("tmo_no_rd", rd_cnt - r0, 0);
      send_byte(8'h41, 1'b1, 2);
      wait_tx("tmo_idle_tx", base + 1);
      check32("tmo_idle_resp", tx_log[base], 8'h3F);
      repeat (2 * BAUD) @(negedge CLK);

      // reset while a write is held by HLT
      base = tx_count;
      HLT = 1'b1;
      send_byte(8'h57, 1'b1, 2);
      send_byte(8'h44, 1'b1, 2); send_byte(8'h00, 1'b1, 2);
      send_byte(8'h00, 1'b1, 2); send_byte(8'h00, 1'b1, 2);
      send_byte(8'h44, 1'b1, 2); send_byte(8'h33, 1'b1, 2);
      send_byte(8'h22, 1'b1, 2); send_byte(8'h11, 1'b1, 2);
      wait_req("res_wr_rise", 1'b0);
      check32("res_wr_data", DATAO, 32'h1122_3344);
      #2 RES = 1'b1;
      #1;
      check32("res_wr_drop", WR,   0);
      check32("res_txd",     TXD,  1);
      check32("res_busy",    BUSY, 0);
      check32("res_addr",    ADDR, 0);
      check32("res_be",      BE,   0);
      @(negedge CLK);
      RES = 1'b0; HLT = 1'b0;
      repeat (200) @(negedge CLK);
      check32("res_no_wr", WR, 0);
      check32("res_no_tx", tx_count, base);

      check32("rd_wr_exclusive", both_cnt, 0);
      check32("tx_stop_bits", tx_bad_stop, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
